// File: rtl/data_mem_ctrl.sv
// Byte-banked RV32I data memory controller with a valid/ready request/response handshake.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of forcing alignment.
module data_mem_ctrl #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_next;
   logic [3:0]  wait_cnt;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q, wdata_q;

   logic        cur_we, commit, err;
   logic [2:0]  cur_funct3;
   logic [31:0] cur_addr, cur_wdata, lane_wdata, rword, load_data;
   logic [3:0]  strb;
   logic [AW-1:0] idx;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   logic [7:0]  mem [4][DEPTH_WORDS];

   // With zero wait states the commit happens on the accept edge, so decode straight from the request.
   assign cur_we     = (state == IDLE) ? req_we     : we_q;
   assign cur_funct3 = (state == IDLE) ? req_funct3 : funct3_q;
   assign cur_addr   = (state == IDLE) ? req_addr   : addr_q;
   assign cur_wdata  = (state == IDLE) ? req_wdata  : wdata_q;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign commit    = (state != RESP) && (state_next == RESP);
   assign idx       = cur_addr[AW+1:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= (state == WAIT && state_next == WAIT) ? wait_cnt + 4'd1 : 4'd0;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (req_valid) state_next = (WAIT_STATES > 0) ? WAIT : RESP;
         WAIT: if (wait_cnt == WS_LAST) state_next = RESP;
         RESP: if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q     <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else if (req_valid && state == IDLE) begin
         we_q     <= req_we;
         funct3_q <= req_funct3;
         addr_q   <= req_addr;
         wdata_q  <= req_wdata;
      end
   end

   always_comb begin
      err = 1'b0;
      case (cur_funct3)
         3'b011, 3'b110, 3'b111: err = 1'b1;
         3'b100, 3'b101:         if (cur_we) err = 1'b1;
         default: ;
      endcase
      if ((cur_addr >> (AW + 2)) != 32'd0) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (cur_funct3[1:0] == 2'b01 && cur_addr[0]) err = 1'b1;
      if (cur_funct3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00) err = 1'b1;
`endif
   end

   // funct3[1:0] is the access size; unaligned low bits are dropped by the strobe pattern.
   always_comb begin
      strb       = 4'b1111;
      lane_wdata = cur_wdata;
      case (cur_funct3[1:0])
         2'b00: begin
            strb       = 4'b0001 << cur_addr[1:0];
            lane_wdata = {4{cur_wdata[7:0]}};
         end
         2'b01: begin
            strb       = cur_addr[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{cur_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (commit && cur_we && !err && strb[l]) mem[l][idx] <= lane_wdata[l*8 +: 8];
      end
   end

   assign rword    = {mem[3][idx], mem[2][idx], mem[1][idx], mem[0][idx]};
   assign byte_sel = 8'(rword >> {cur_addr[1:0], 3'b000});
   assign half_sel = cur_addr[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      load_data = '0;
      case (cur_funct3)
         3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001: load_data = {{16{half_sel[15]}}, half_sel};
         3'b010: load_data = rword;
         3'b100: load_data = {24'd0, byte_sel};
         3'b101: load_data = {16'd0, half_sel};
         default: ;
      endcase
      if (err || cur_we) load_data = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else if (commit) begin
         rsp_rdata <= load_data;
         rsp_err   <= err;
      end
   end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a byte-addressed memory model.
// Honours DMEM_MISALIGN_TRAP_EN in its expectations.
module tb_data_mem_ctrl;
   localparam int DEPTH = 256;
   localparam int WS    = 1;
   localparam int BYTES = DEPTH * 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b010;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int failures = 0;
   logic [7:0] model_mem [BYTES];

   data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // Reference: byte-addressed array, sizes in bytes, alignment by modulo arithmetic.
   function automatic void model_access(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr, input logic [31:0] wdata,
                                        output logic [31:0] rdata, output logic err);
      int size;
      int base;
      logic [31:0] v;
      err = 1'b0;
      rdata = '0;
      size = 1;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    err = 1'b1;
      endcase
      if (we && (f3 == 3'd4 || f3 == 3'd5)) err = 1'b1;
      if (addr >= 32'(BYTES)) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((addr % size) != 0) err = 1'b1;
`endif
      if (err) return;
      base = int'(addr) - int'(addr % size);
      if (we) begin
         for (int i = 0; i < size; i++) model_mem[base + i] = wdata[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < size; i++) v = v | (32'(model_mem[base + i]) << (8 * i));
         if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
         if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
         rdata = v;
      end
   endfunction

   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
      @(negedge clk);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_funct3 = 3'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            lat = k;
            break;
         end
         @(posedge clk);
      end
      rdata = rsp_rdata;
      err = rsp_err;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      checks++;
      if (rsp_rdata !== 32'd0) begin failures++; $display("[TB] FAIL reset_rdata got=%h want=0", rsp_rdata); end
      checks++;
      if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b want=0", rsp_err); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got=%b want=1", req_ready); end
   endtask

   task automatic init_mem;
      logic [31:0] r; logic e; int l;
      for (int w = 0; w < DEPTH; w++) do_req(1'b1, 3'b010, 32'(w * 4), 32'd0, r, e, l);
      for (int b = 0; b < BYTES; b++) model_mem[b] = 8'd0;
   endtask

   task automatic test_word;
      logic [31:0] r, er; logic e, ee; int l;
      model_access(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, er, ee);
      do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, r, e, l);
      checks++;
      if (e !== 1'b0 || l != WS) begin failures++; $display("[TB] FAIL store_w err=%b lat=%0d want err=0 lat=%0d", e, l, WS); end
      model_access(1'b0, 3'b010, 32'h10, 32'd0, er, ee);
      do_req(1'b0, 3'b010, 32'h10, 32'd0, r, e, l);
      checks++;
      if (r !== er || r !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL load_w got=%h want=%h", r, er); end
      checks++;
      if (e !== 1'b0) begin failures++; $display("[TB] FAIL load_w_err got=%b want=0", e); end
      checks++;
      if (l + 1 != WS + 1) begin failures++; $display("[TB] FAIL load_w_latency got=%0d want=%0d", l + 1, WS + 1); end
   endtask

   task automatic test_byte;
      logic [31:0] r, er; logic e, ee; int l;
      logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b010};
      logic [31:0] ads [3] = '{32'h13, 32'h13, 32'h10};
      logic [31:0] lit [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h80AD_BEEF};
      model_access(1'b1, 3'b000, 32'h13, 32'h0000_0080, er, ee);
      do_req(1'b1, 3'b000, 32'h13, 32'h0000_0080, r, e, l);
      for (int i = 0; i < 3; i++) begin
         model_access(1'b0, f3s[i], ads[i], 32'd0, er, ee);
         do_req(1'b0, f3s[i], ads[i], 32'd0, r, e, l);
         checks++;
         if (r !== er || r !== lit[i] || e !== 1'b0) begin
            failures++;
            $display("[TB] FAIL byte_load%0d got=%h err=%b want=%h err=0", i, r, e, lit[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] r, er, held; logic e, ee; int l;
      model_access(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, er, ee);
      do_req(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, r, e, l);
      model_access(1'b0, 3'b010, 32'h30, 32'd0, er, ee);
      @(negedge clk);
      req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      l = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin l = k; break; end
      end
      checks++;
      if (l < 0) begin failures++; $display("[TB] FAIL bp_timeout got=no_rsp want=rsp_valid"); end
      held = rsp_rdata;
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h1111_1111;
      req_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== er || rsp_rdata !== held || req_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_hold%0d valid=%b rdata=%h ready=%b want valid=1 rdata=%h ready=0",
                     c, rsp_valid, rsp_rdata, req_ready, er);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL bp_release valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
      end
      do_req(1'b0, 3'b010, 32'h30, 32'd0, r, e, l);
      checks++;
      if (r !== er) begin failures++; $display("[TB] FAIL bp_ignored_store got=%h want=%h", r, er); end
   endtask

   task automatic test_out_of_range;
      logic [31:0] r, er; logic e, ee; int l;
      do_req(1'b0, 3'b010, 32'h400, 32'd0, r, e, l);
      checks++;
      if (e !== 1'b1 || r !== 32'd0) begin failures++; $display("[TB] FAIL oor_load err=%b rdata=%h want err=1 rdata=0", e, r); end
      model_access(1'b1, 3'b010, 32'h400, 32'hFFFF_FFFF, er, ee);
      do_req(1'b1, 3'b010, 32'h400, 32'hFFFF_FFFF, r, e, l);
      checks++;
      if (e !== 1'b1) begin failures++; $display("[TB] FAIL oor_store_err got=%b want=1", e); end
      model_access(1'b0, 3'b010, 32'h0, 32'd0, er, ee);
      do_req(1'b0, 3'b010, 32'h0, 32'd0, r, e, l);
      checks++;
      if (r !== er || r !== 32'd0) begin failures++; $display("[TB] FAIL oor_word0 got=%h want=%h", r, er); end
      do_req(1'b0, 3'b000, 32'h8000_0004, 32'd0, r, e, l);
      checks++;
      if (e !== 1'b1 || r !== 32'd0) begin failures++; $display("[TB] FAIL oor_high err=%b rdata=%h want err=1 rdata=0", e, r); end
   endtask

   task automatic test_misalign;
      logic [31:0] r, er; logic e, ee; int l;
      model_access(1'b1, 3'b001, 32'h21, 32'h0000_1234, er, ee);
      do_req(1'b1, 3'b001, 32'h21, 32'h0000_1234, r, e, l);
      checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (e !== 1'b1) begin failures++; $display("[TB] FAIL misalign_err got=%b want=1", e); end
`else
      if (e !== 1'b0) begin failures++; $display("[TB] FAIL misalign_err got=%b want=0", e); end
`endif
      model_access(1'b0, 3'b001, 32'h20, 32'd0, er, ee);
      do_req(1'b0, 3'b001, 32'h20, 32'd0, r, e, l);
      checks++;
      if (r !== er || e !== ee) begin failures++; $display("[TB] FAIL misalign_load got=%h err=%b want=%h err=%b", r, e, er, ee); end
   endtask

   task automatic test_reset_inflight;
      logic [31:0] r, er; logic e, ee; int l;
      @(negedge clk);
      req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h5A5A_5A5A;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL inflight_rst_valid got=%b want=0", rsp_valid); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL inflight_after valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
      end
      model_access(1'b0, 3'b010, 32'h0, 32'd0, er, ee);
      do_req(1'b0, 3'b010, 32'h0, 32'd0, r, e, l);
      checks++;
      if (r !== er || r !== 32'd0) begin failures++; $display("[TB] FAIL inflight_no_write got=%h want=%h", r, er); end
   endtask

   task automatic test_random;
      logic [31:0] r, er, a, wd; logic e, ee, we; logic [2:0] f3; int l;
      for (int n = 0; n < 200; n++) begin
         we = 1'($urandom);
         f3 = 3'($urandom);
         a  = 32'($urandom_range(0, BYTES - 1));
         if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(10, 31));
         wd = $urandom;
         model_access(we, f3, a, wd, er, ee);
         do_req(we, f3, a, wd, r, e, l);
         checks++;
         if (r !== er || e !== ee || l != WS) begin
            failures++;
            $display("[TB] FAIL rand%0d we=%b f3=%b addr=%h got=%h err=%b lat=%0d want=%h err=%b lat=%0d",
                     n, we, f3, a, r, e, l, er, ee, WS);
         end
      end
   endtask

   initial begin
      test_reset;
      init_mem;
      test_word;
      test_byte;
      test_backpressure;
      test_out_of_range;
      test_misalign;
      test_reset_inflight;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
